// File: rtl/gfx_pkg.sv
// Shared opcodes, FSM state encoding and operand sizing helpers for gfx_cmd_engine.
package gfx_pkg;

    localparam logic [7:0] OP_POINT = 8'h50;
    localparam logic [7:0] OP_LINE  = 8'h4C;
    localparam logic [7:0] OP_RECT  = 8'h52;

    typedef enum logic [1:0] {IDLE, LOAD, SETUP, EMIT} state_t;

    // Bytes per coordinate / colour field, little-endian on the byte stream.
    function automatic int NB(input int cw);
        return (cw + 7) / 8;
    endfunction

    function automatic int NC(input int colw);
        return (colw + 7) / 8;
    endfunction

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_POINT) || (b == OP_LINE) || (b == OP_RECT);
    endfunction

endpackage

// File: rtl/gfx_cmd_engine_bresenham_step.sv
// One combinational Bresenham iteration: next (x, y, err) and whether (x, y) is the endpoint.
module bresenham_step
    import gfx_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    input  logic [CW-1:0]        xe,
    input  logic [CW-1:0]        ye,
    input  logic signed [CW+1:0] err,
    input  logic signed [CW+1:0] dx,
    input  logic signed [CW+1:0] dy,
    input  logic                 sx,   // 1 = step towards smaller x
    input  logic                 sy,   // 1 = step towards smaller y
    output logic [CW-1:0]        x_next,
    output logic [CW-1:0]        y_next,
    output logic signed [CW+1:0] err_next,
    output logic                 done
);

    logic signed [CW+2:0] e2;
    logic signed [CW+2:0] dx_w;
    logic signed [CW+2:0] dy_w;

    // NOTE: blocking assignments here are intentional; err_next is accumulated
    // in program order, and every output gets a default first so no latch is inferred.
    always_comb begin
        e2       = {err, 1'b0};
        dx_w     = {dx[CW+1], dx};
        dy_w     = {dy[CW+1], dy};
        done     = (x == xe) && (y == ye);
        x_next   = x;
        y_next   = y;
        err_next = err;
        if (e2 >= dy_w) begin
            err_next = err_next + dy;
            x_next   = sx ? x - 1'b1 : x + 1'b1;
        end
        if (e2 <= dx_w) begin
            err_next = err_next + dx;
            y_next   = sy ? y - 1'b1 : y + 1'b1;
        end
    end

endmodule

// File: rtl/gfx_cmd_engine.sv
// Byte-serial graphics command engine: collects point/line/rect operands and
// streams the rasterised (x, y, colour) pixels on a valid/ready port.
module gfx_cmd_engine
    import gfx_pkg::*;
#(
    parameter int CW   = 8,
    parameter int COLW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [CW-1:0]   pix_x,
    output logic [CW-1:0]   pix_y,
    output logic [COLW-1:0] pix_color,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            busy,
    output logic            err_cmd
);

    localparam int NBY  = NB(CW);
    localparam int NCY  = NC(COLW);
    localparam int TOT  = 4 * NBY + NCY;
    localparam int CNTW = $clog2(TOT);
    localparam logic [CNTW-1:0] LAST_SHORT = CNTW'(2 * NBY + NCY - 1);
    localparam logic [CNTW-1:0] LAST_LONG  = CNTW'(TOT - 1);

    typedef logic signed [CW+1:0] sword_t;

    state_t          state, state_nx;
    logic [7:0]      op;
    logic [CNTW-1:0] cnt;
    logic [8*TOT-1:0] opr;
    logic [CW-1:0]   x, y, xe, ye, xlo;
    logic [COLW-1:0] color;
    sword_t          err, dx, dy;
    logic            sx, sy;

    logic            accept, last_byte, is_rect, step_done, done, pix_fire;
    logic [CW-1:0]   bx_next, by_next;
    sword_t          berr_next;

    // After a full shift the fields sit as X0, Y0, X1, Y1, C. A point shifts in
    // fewer bytes, so its X, Y, C land in the X1, Y1, C slots.
    logic [CW-1:0]   f_x0, f_y0, f_x1, f_y1, f_xs, f_ys;
    logic [CW-1:0]   x_min, x_max, y_min, y_max;
    logic [COLW-1:0] f_c;
    sword_t          ddx, ddy, adx, ady;

    assign f_x0  = opr[0 +: CW];
    assign f_y0  = opr[8*NBY +: CW];
    assign f_x1  = opr[16*NBY +: CW];
    assign f_y1  = opr[24*NBY +: CW];
    assign f_c   = opr[32*NBY +: COLW];
    assign f_xs  = (op == OP_POINT) ? f_x1 : f_x0;
    assign f_ys  = (op == OP_POINT) ? f_y1 : f_y0;
    assign ddx   = $signed({2'b00, f_x1}) - $signed({2'b00, f_xs});
    assign ddy   = $signed({2'b00, f_y1}) - $signed({2'b00, f_ys});
    assign adx   = ddx[CW+1] ? -ddx : ddx;
    assign ady   = ddy[CW+1] ? -ddy : ddy;
    assign x_min = (f_x0 < f_x1) ? f_x0 : f_x1;
    assign x_max = (f_x0 < f_x1) ? f_x1 : f_x0;
    assign y_min = (f_y0 < f_y1) ? f_y0 : f_y1;
    assign y_max = (f_y0 < f_y1) ? f_y1 : f_y0;

    assign accept    = cmd_valid && cmd_ready;
    assign is_rect   = (op == OP_RECT);
    assign last_byte = (state == LOAD) && accept &&
                       (cnt == ((op == OP_POINT) ? LAST_SHORT : LAST_LONG));
    assign done      = is_rect ? ((x == xe) && (y == ye)) : step_done;
    assign pix_fire  = pix_valid && pix_ready;

    assign pix_x     = x;
    assign pix_y     = y;
    assign pix_color = color;

    bresenham_step #(.CW(CW)) u_step (
        .x        (x),
        .y        (y),
        .xe       (xe),
        .ye       (ye),
        .err      (err),
        .dx       (dx),
        .dy       (dy),
        .sx       (sx),
        .sy       (sy),
        .x_next   (bx_next),
        .y_next   (by_next),
        .err_next (berr_next),
        .done     (step_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_opcode(cmd_data)) state_nx = LOAD;
            LOAD:    if (last_byte) state_nx = SETUP;
            SETUP:   state_nx = EMIT;
            EMIT:    if (pix_fire && done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cmd_ready is masked by rst so the host sees it low while reset is held.
    always_comb begin
        cmd_ready = ((state == IDLE) || (state == LOAD)) && !rst;
        busy      = (state != IDLE);
        pix_valid = (state == EMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= '0;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            xe      <= '0;
            ye      <= '0;
            xlo     <= '0;
            color   <= '0;
            err     <= '0;
            dx      <= '0;
            dy      <= '0;
            sx      <= 1'b0;
            sy      <= 1'b0;
            err_cmd <= 1'b0;
        end else begin
            err_cmd <= (state == IDLE) && accept && !is_opcode(cmd_data);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) op <= cmd_data;
                end
                LOAD: if (accept) cnt <= cnt + 1'b1;
                SETUP: begin
                    color <= f_c;
                    if (is_rect) begin
                        x   <= x_min;
                        xlo <= x_min;
                        xe  <= x_max;
                        y   <= y_min;
                        ye  <= y_max;
                    end else begin
                        x   <= f_xs;
                        y   <= f_ys;
                        xe  <= f_x1;
                        ye  <= f_y1;
                        dx  <= adx;
                        dy  <= -ady;
                        sx  <= ddx[CW+1];
                        sy  <= ddy[CW+1];
                        err <= adx - ady;
                    end
                end
                EMIT: if (pix_fire && !done) begin
                    if (is_rect) begin
                        if (x == xe) begin
                            x <= xlo;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end else begin
                        x   <= bx_next;
                        y   <= by_next;
                        err <= berr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand register has no reset; it is only read in SETUP,
    // after every byte it contributes has been freshly shifted in.
    always_ff @(posedge clk) begin
        if (accept && (state == LOAD)) opr <= {cmd_data, opr[8*TOT-1:8]};
    end

endmodule

// File: tb/tb_gfx_cmd_engine.sv
// Directed plus randomised bench for gfx_cmd_engine against a queue-based pixel model.
module tb_gfx_cmd_engine;
    import gfx_pkg::*;

    localparam int CW   = 8;
    localparam int COLW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      cmd_data = '0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [CW-1:0]   pix_x, pix_y;
    logic [COLW-1:0] pix_color;
    logic            pix_valid;
    logic            pix_ready = 1'b0;
    logic            busy, err_cmd;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    gfx_cmd_engine #(.CW(CW), .COLW(COLW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .err_cmd   (err_cmd)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int px, input int py, input int pc);
        logic [7:0] a, b, c;
        a = px[7:0];
        b = py[7:0];
        c = pc[7:0];
        return {a, b, c};
    endfunction

    // Reference raster: the pixel list a command must produce, in order.
    task automatic model(input logic [7:0] op, input int a, input int b, input int c,
                         input int d, input int col);
        int x, y, dx, dy, sx, sy, err, e2, xmn, xmx, ymn, ymx;
        exp_q.delete();
        if (op == OP_POINT) begin
            exp_q.push_back(pk(a, b, col));
        end else if (op == OP_RECT) begin
            xmn = (a < c) ? a : c;  xmx = (a < c) ? c : a;
            ymn = (b < d) ? b : d;  ymx = (b < d) ? d : b;
            for (int yy = ymn; yy <= ymx; yy++)
                for (int xx = xmn; xx <= xmx; xx++)
                    exp_q.push_back(pk(xx, yy, col));
        end else begin
            x  = a;  y = b;
            dx = (c > a) ? c - a : a - c;
            dy = -((d > b) ? d - b : b - d);
            sx = (a < c) ? 1 : -1;
            sy = (b < d) ? 1 : -1;
            err = dx + dy;
            for (int k = 0; k < 2048; k++) begin
                exp_q.push_back(pk(x, y, col));
                if (x == c && y == d) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout: cmd_ready observed 0 required 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input int a, input int b, input int c,
                            input int d, input int col);
        logic [7:0] bytes[$];
        bytes.delete();
        bytes.push_back(op);
        bytes.push_back(8'(a));
        bytes.push_back(8'(b));
        if (op != OP_POINT) begin
            bytes.push_back(8'(c));
            bytes.push_back(8'(d));
        end
        bytes.push_back(8'(col));
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    // mode 0: ready always high; 1: stall hold_n cycles on pixel hold_idx; 2: random ready.
    task automatic run_cmd(input string tag, input logic [7:0] op, input int a, input int b,
                           input int c, input int d, input int col,
                           input int mode, input int hold_idx, input int hold_n);
        int idx, held, n, limit;
        if (op == OP_POINT) model(op, a, b, a, b, col);
        else                model(op, a, b, c, d, col);
        send_cmd(op, a, b, c, d, col);
        check({tag, "_setup_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_setup_busy"},  32'(busy),      32'd1);
        check({tag, "_setup_ready"}, 32'(cmd_ready), 32'd0);
        idx = 0; held = 0; n = 0;
        limit = 8 * exp_q.size() + 50;
        @(negedge clk);
        while (exp_q.size() > 0 && n < limit) begin
            check({tag, "_valid"}, 32'(pix_valid), 32'd1);
            check({tag, "_pix"}, 32'({pix_x, pix_y, pix_color}), 32'(exp_q[0]));
            if (mode == 1 && idx == hold_idx && held < hold_n) begin
                pix_ready = 1'b0;
                held++;
            end else if (mode == 2) begin
                pix_ready = ($urandom_range(0, 3) != 0);
            end else begin
                pix_ready = 1'b1;
            end
            if (pix_ready && pix_valid) begin
                void'(exp_q.pop_front());
                idx++;
            end
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: %0d pixels still outstanding, required 0", tag, exp_q.size());
        end
        pix_ready = 1'b0;
        check({tag, "_end_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_end_busy"},  32'(busy),      32'd0);
        check({tag, "_end_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int a, b, c, d, col, sel;
        logic [7:0] op;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_outputs", 32'({pix_valid, busy, err_cmd, pix_x, pix_y, pix_color}), 32'd0);
        rst = 1'b0;
        #1;
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        run_cmd("point",      OP_POINT, 5, 7, 0, 0, 8'h1F, 0, 0, 0);
        run_cmd("shallow",    OP_LINE,  0, 0, 4, 2, 8'h33, 0, 0, 0);
        run_cmd("backpress",  OP_LINE,  0, 0, 4, 2, 8'h33, 1, 1, 3);
        run_cmd("rev_diag",   OP_LINE,  3, 3, 0, 0, 8'h07, 0, 0, 0);
        run_cmd("degenerate", OP_LINE,  9, 9, 9, 9, 8'h5A, 0, 0, 0);
        run_cmd("rect_swap",  OP_RECT,  2, 3, 1, 2, 8'hAA, 0, 0, 0);

        send_byte(8'h41);
        check("bad_op_err_pulse", 32'(err_cmd),   32'd1);
        check("bad_op_busy",      32'(busy),      32'd0);
        check("bad_op_ready",     32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("bad_op_err_clear", 32'(err_cmd),   32'd0);

        // Abort a line after its second pixel handshake.
        model(OP_LINE, 0, 0, 4, 2, 8'h33);
        send_cmd(OP_LINE, 0, 0, 4, 2, 8'h33);
        @(negedge clk);
        pix_ready = 1'b1;
        check("abort_pix0", 32'({pix_x, pix_y, pix_color}), 32'(exp_q[0]));
        @(negedge clk);
        check("abort_pix1", 32'({pix_x, pix_y, pix_color}), 32'(exp_q[1]));
        @(negedge clk);
        rst = 1'b1;
        pix_ready = 1'b0;
        #1;
        check("abort_outputs", 32'({pix_valid, busy, err_cmd, pix_x, pix_y, pix_color}), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", 32'(cmd_ready), 32'd1);
        check("abort_no_pixel",   32'(pix_valid), 32'd0);
        run_cmd("post_reset_point", OP_POINT, 200, 17, 0, 0, 8'hC3, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 2);
            col = $urandom_range(0, 255);
            if (sel == 0) begin
                op = OP_POINT;
                a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = 0; d = 0;
            end else if (sel == 1) begin
                op = OP_LINE;
                a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                c = $urandom_range(0, 255); d = $urandom_range(0, 255);
            end else begin
                op = OP_RECT;
                a = $urandom_range(0, 240); b = $urandom_range(0, 240);
                c = a + $urandom_range(0, 15); d = b + $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 1) begin
                    sel = a; a = c; c = sel;
                end
            end
            run_cmd("random", op, a, b, c, d, col, 2, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
